serial_multiply_uu: RTL

Serial unsigned shift-add multiplier that produces one multiplier bit per enabled clock. It is the companion of the serial unsigned divider. It is used where area matters more than latency, e.g. rescaling a divider quotient back into counts for PWM and measurement paths. Operands are captured on a start pulse, so the inputs need not be held during the operation.

---
 rtl/serial_multiply_uu_if.sv | 24 ++
 rtl/serial_multiply_uu.sv | 80 ++++++++
 2 files changed

// File: rtl/serial_multiply_uu_if.sv
// Handshake and data bundle for the serial unsigned multiplier.
// The master side drives the operands and start pulse; the slave side returns the product and status.
interface serial_multiply_uu_if #(
    parameter int M_PP = 16,
    parameter int N_PP = 8
);
    logic                   clk_en_i;
    logic                   multiply_i;
    logic [M_PP-1:0]        multiplicand_i;
    logic [N_PP-1:0]        multiplier_i;
    logic [M_PP+N_PP-1:0]   product_o;
    logic                   busy_o;
    logic                   done_o;

    modport master (
        output clk_en_i, multiply_i, multiplicand_i, multiplier_i,
        input  product_o, busy_o, done_o
    );

    modport slave (
        input  clk_en_i, multiply_i, multiplicand_i, multiplier_i,
        output product_o, busy_o, done_o
    );
endinterface

// File: rtl/serial_multiply_uu.sv
// Serial unsigned shift-add multiplier: one multiplier bit is consumed per enabled clock,
// N_PP enabled edges from start to a valid product.
//   state  | meaning
//   S_IDLE | out of reset, waiting for a start
//   S_RUN  | accumulating, one multiplier bit per enabled edge
//   S_DONE | product valid, held until the next start
module serial_multiply_uu #(
    parameter int M_PP           = 16,
    parameter int N_PP           = 8,
    parameter int COUNT_WIDTH_PP = 4,
    parameter int HELD_OUTPUT_PP = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    serial_multiply_uu_if.slave bus
);
    localparam int P_W = M_PP + N_PP;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    r_state;
    logic [P_W-1:0]            r_acc;
    logic [P_W-1:0]            r_held;
    logic [M_PP-1:0]           r_mcand;
    logic [N_PP-1:0]           r_mplr;
    logic [COUNT_WIDTH_PP-1:0] r_count;
    logic                      r_busy;
    logic                      r_done;

    logic [M_PP:0]             w_sum;
    logic [P_W-1:0]            w_acc_next;
    logic                      w_last;

    // The carry out of the partial sum enters at the accumulator MSB as it shifts right.
    assign w_sum      = {1'b0, r_acc[P_W-1:N_PP]} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {w_sum, r_acc[N_PP-1:1]};
    assign w_last     = (r_count == COUNT_WIDTH_PP'(N_PP - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_held  <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.clk_en_i) begin
            if (bus.multiply_i) begin
                r_mcand <= bus.multiplicand_i;
                r_mplr  <= bus.multiplier_i;
                r_acc   <= '0;
                r_count <= '0;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_state <= S_RUN;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_acc   <= w_acc_next;
                        r_mplr  <= r_mplr >> 1;
                        r_count <= r_count + 1'b1;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            if (HELD_OUTPUT_PP != 0) r_held <= w_acc_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.product_o = (HELD_OUTPUT_PP != 0) ? r_held : r_acc;
    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
endmodule
